// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break).
package mem_arbiter_pkg;

  localparam int BLK_ADDR_W_DEF = 6;
  localparam int BLK_DATA_W_DEF = 32;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS_D = 2'd1,
    ACCESS_I = 2'd2
  } arb_state_e;

  // Requester identity (data cache / instruction cache)
  typedef enum logic {
    REQ_D = 1'b0,
    REQ_I = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Grant selection between the data-cache and instruction-cache requests.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When defined, a tie goes to the
// requester that was not granted most recently; otherwise dcache always wins.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic    d_req,
  input  logic    i_req,
  input  req_id_e last_grant,
  output req_id_e grant,
  output logic    valid
);

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority ignores the history input; keep it visibly consumed.
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == REQ_I);
`endif

  // Pick a single requester; dcache is the default on a tie
  always_comb begin
    valid = d_req | i_req;
    grant = REQ_D;
    if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant = (last_grant == REQ_D) ? REQ_I : REQ_D;
`else
      grant = REQ_D;
`endif
    end else if (i_req) begin
      grant = REQ_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a data cache (read/write) and an instruction
// cache (read-only) share one memory port. One access at a time; each
// completed access produces a one-cycle ack that masks the finished
// requester for that cycle, so a waiting requester is granted immediately.
// Optional feature macro: ARB_ROUND_ROBIN_EN (adds a last-grant register and
// round-robin tie breaking).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BLK_ADDR_W = BLK_ADDR_W_DEF,
  parameter int BLK_DATA_W = BLK_DATA_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  // data cache
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [BLK_ADDR_W-1:0] d_address,
  input  logic [BLK_DATA_W-1:0] d_writedata,
  output logic [BLK_DATA_W-1:0] d_readdata,
  output logic                  d_busywait,
  // instruction cache
  input  logic                  i_read,
  input  logic [BLK_ADDR_W-1:0] i_address,
  output logic [BLK_DATA_W-1:0] i_readdata,
  output logic                  i_busywait,
  // memory
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BLK_ADDR_W-1:0] mem_address,
  output logic [BLK_DATA_W-1:0] mem_writedata,
  input  logic [BLK_DATA_W-1:0] mem_readdata,
  input  logic                  mem_busywait
);

  arb_state_e            state_q, state_d;
  logic                  entry_q, entry_d;   // high during the first cycle of an access
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [BLK_ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [BLK_DATA_W-1:0] mem_writedata_q, mem_writedata_d;
  logic [BLK_DATA_W-1:0] d_readdata_q, d_readdata_d;
  logic [BLK_DATA_W-1:0] i_readdata_q, i_readdata_d;
  logic                  d_ack_q, d_ack_d;
  logic                  i_ack_q, i_ack_d;

  logic                  d_req, i_req;
  logic                  pick_valid;
  req_id_e               pick_grant;
  req_id_e               last_grant;

  // A requester being acked this cycle is not a new request
  assign d_req = (d_read | d_write) & ~d_ack_q;
  assign i_req = i_read & ~i_ack_q;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_e last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = REQ_I;
`endif

  arb_pick u_pick (
    .d_req      (d_req),
    .i_req      (i_req),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // Next-state and datapath: grant in IDLE, wait out the memory, then ack
  always_comb begin
    state_d         = state_q;
    entry_d         = 1'b0;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    d_readdata_d    = d_readdata_q;
    i_readdata_d    = i_readdata_q;
    d_ack_d         = 1'b0;
    i_ack_d         = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d    = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          entry_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = pick_grant;
`endif
          if (pick_grant == REQ_D) begin
            state_d         = ACCESS_D;
            // write wins when both strobes are raised together
            mem_write_d     = d_write;
            mem_read_d      = ~d_write;
            mem_address_d   = d_address;
            mem_writedata_d = d_writedata;
          end else begin
            state_d       = ACCESS_I;
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
            mem_address_d = i_address;
          end
        end
      end
      ACCESS_D, ACCESS_I: begin
        // The memory cannot have reacted during the entry cycle, so its
        // busywait is only trusted from the second cycle on.
        if (!entry_q && !mem_busywait) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (state_q == ACCESS_D) begin
            d_ack_d = 1'b1;
            if (mem_read_q) begin
              d_readdata_d = mem_readdata;
            end
          end else begin
            i_ack_d      = 1'b1;
            i_readdata_d = mem_readdata;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      entry_q         <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      d_readdata_q    <= '0;
      i_readdata_q    <= '0;
      d_ack_q         <= 1'b0;
      i_ack_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      entry_q         <= entry_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      d_readdata_q    <= d_readdata_d;
      i_readdata_q    <= i_readdata_d;
      d_ack_q         <= d_ack_d;
      i_ack_q         <= i_ack_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who was granted last; reset favours dcache on the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= REQ_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign d_readdata    = d_readdata_q;
  assign i_readdata    = i_readdata_q;
  assign d_busywait    = d_req;
  assign i_busywait    = i_req;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a simple busy-counting memory, a
// transaction-level model predicting strobes, busywaits, acks and read data,
// and directed scenarios with literal expectations.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        d_read, d_write, i_read;
  logic [5:0]  d_address, i_address;
  logic [31:0] d_writedata;
  logic [31:0] d_readdata, i_readdata;
  logic        d_busywait, i_busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_busywait;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_writedata   (d_writedata),
    .d_readdata    (d_readdata),
    .d_busywait    (d_busywait),
    .i_read        (i_read),
    .i_address     (i_address),
    .i_readdata    (i_readdata),
    .i_busywait    (i_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [5:0] a);
    case (a)
      6'h05:   return 32'hDEADBEEF;
      6'h07:   return 32'h0BADF00D;
      default: return 32'h1000_0000 + {26'd0, a} * 32'h0001_0011;
    endcase
  endfunction

  // ---------------- memory: busy for mem_lat cycles after seeing a strobe
  int          mem_lat = 1;
  int          edge_cnt = 0;
  int          m_cnt = 0;
  bit          m_active = 1'b0;
  bit   [31:0] mem_arr [64];
  bit          mem_wr_valid [64];
  int          mem_read_cnt = 0;
  logic [5:0]  log_addr [$];
  bit          log_wr [$];
  logic [31:0] log_wdata [$];
  int          log_cyc [$];

  assign mem_readdata = mem_wr_valid[mem_address] ? mem_arr[mem_address] : init_val(mem_address);
  assign mem_busywait = m_active && (m_cnt != 0);

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  always @(posedge clock) begin
    if (mem_read) mem_read_cnt++;
    if (!(mem_read || mem_write)) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
    end else if (!m_active) begin
      m_active <= 1'b1;
      m_cnt    <= mem_lat;
      log_addr.push_back(mem_address);
      log_wr.push_back(mem_write);
      log_wdata.push_back(mem_writedata);
      log_cyc.push_back(edge_cnt);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && mem_write) begin
        mem_arr[mem_address]      <= mem_writedata;
        mem_wr_valid[mem_address] <= 1'b1;
      end
    end
  end

  // ---------------- model: one access at a time, finishing mem_lat+2 edges
  // after its grant edge; a finished requester is masked during its ack cycle.
  bit          m_started = 1'b0;
  int          m_cyc = 0;
  bit          m_busy, m_owner_i, m_wr, m_ackd, m_acki, m_last;
  int          m_done;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata, m_rd_d, m_rd_i;
  bit   [31:0] model_mem [64];
  bit          model_wr [64];

  function automatic logic [31:0] mm_read(input logic [5:0] a);
    return model_wr[a] ? model_mem[a] : init_val(a);
  endfunction

  always @(posedge clock) begin : model_p
    bit nd, ni, dreq, ireq, take_i;
    m_cyc++;
    m_started = 1'b1;
    if (reset) begin
      m_busy = 0; m_ackd = 0; m_acki = 0; m_rd_d = '0; m_rd_i = '0; m_last = 1'b1;
    end else begin
      nd = 0;
      ni = 0;
      if (m_busy) begin
        if (m_cyc == m_done) begin
          m_busy = 0;
          if (m_owner_i) begin
            ni = 1; m_rd_i = mm_read(m_addr);
          end else begin
            nd = 1;
            if (m_wr) begin model_mem[m_addr] = m_wdata; model_wr[m_addr] = 1'b1; end
            else m_rd_d = mm_read(m_addr);
          end
        end
      end else begin
        dreq = (d_read || d_write) && !m_ackd;
        ireq = i_read && !m_acki;
        if (dreq || ireq) begin
          take_i = ireq && !dreq;
`ifdef ARB_ROUND_ROBIN_EN
          if (dreq && ireq) take_i = (m_last == 1'b0);
`endif
          m_last    = take_i;
          m_busy    = 1;
          m_owner_i = take_i;
          m_done    = m_cyc + mem_lat + 2;
          if (take_i) begin m_wr = 0; m_addr = i_address; end
          else begin m_wr = d_write; m_addr = d_address; m_wdata = d_writedata; end
        end
      end
      m_ackd = nd;
      m_acki = ni;
    end
  end

  // ---------------- compare DUT against the model every cycle
  always @(negedge clock) begin
    if (m_started) begin
      chk("mem_read", 32'(mem_read), 32'(m_busy && !m_wr));
      chk("mem_write", 32'(mem_write), 32'(m_busy && m_wr));
      chk("d_busywait", 32'(d_busywait), 32'((d_read || d_write) && !m_ackd));
      chk("i_busywait", 32'(i_busywait), 32'(i_read && !m_acki));
      chk("d_readdata", d_readdata, m_rd_d);
      chk("i_readdata", i_readdata, m_rd_i);
      if (m_busy) begin
        chk("mem_address", 32'(mem_address), 32'(m_addr));
        if (m_wr) chk("mem_writedata", mem_writedata, m_wdata);
      end
    end
  end

  // ---------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold requests until each requester has seen the given number of acks.
  task automatic serve(input int d_n, input int i_n, input int max_cyc, output int d_wait);
    int dl, il;
    bit dbw, ibw;
    dl = d_n; il = i_n; d_wait = 0;
    for (int k = 0; k < max_cyc && (dl > 0 || il > 0); k++) begin
      @(negedge clock);
      dbw = d_busywait;
      ibw = i_busywait;
      if (dl > 0 && dbw) d_wait++;
      @(posedge clock);
      #1;
      if (dl > 0 && !dbw) begin
        dl--;
        if (dl == 0) begin d_read = 0; d_write = 0; end
      end
      if (il > 0 && !ibw) begin
        il--;
        if (il == 0) i_read = 0;
      end
    end
    chk("serve_done", 32'(dl + il), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w, base, rd0;
    reset = 1; d_read = 0; d_write = 0; i_read = 0;
    d_address = '0; i_address = '0; d_writedata = '0;
    tick(2);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_writedata", mem_writedata, 32'd0);
    chk("rst_d_readdata", d_readdata, 32'd0);
    reset = 0;
    tick(1);

    // single dcache read, memory busy 5 cycles
    mem_lat = 5; base = log_addr.size();
    d_address = 6'h05; d_read = 1;
    serve(1, 0, 40, w);
    $display("T1 dread addr=05 data=%h wait=%0d", d_readdata, w);
    chk("t1_wait_cycles", 32'(w), 32'd8);
    chk("t1_readdata", d_readdata, 32'hDEADBEEF);
    chk("t1_txn_count", 32'(log_addr.size() - base), 32'd1);
    chk("t1_addr", 32'(log_addr[base]), 32'h05);
    chk("t1_is_read", 32'(log_wr[base]), 32'd0);
    tick(1);

    // single dcache write
    mem_lat = 3; base = log_addr.size(); rd0 = mem_read_cnt;
    d_address = 6'h3F; d_writedata = 32'h12345678; d_write = 1;
    serve(1, 0, 40, w);
    $display("T2 dwrite addr=3F data=%h", mem_arr[63]);
    chk("t2_is_write", 32'(log_wr[base]), 32'd1);
    chk("t2_wdata", log_wdata[base], 32'h12345678);
    chk("t2_addr", 32'(log_addr[base]), 32'h3F);
    chk("t2_no_read", 32'(mem_read_cnt - rd0), 32'd0);
    chk("t2_mem", mem_arr[63], 32'h12345678);
    tick(1);

    // fresh reset so both arbitration policies start from the same history
    reset = 1; tick(1); reset = 0; tick(1);

    // simultaneous requests: dcache first, icache on dcache ack cycle
    mem_lat = 2; base = log_addr.size();
    d_address = 6'h01; i_address = 6'h02; d_read = 1; i_read = 1;
    serve(1, 1, 60, w);
    $display("T3 conflict order=%h,%h gap=%0d", log_addr[base], log_addr[base+1], log_cyc[base+1] - log_cyc[base]);
    chk("t3_first", 32'(log_addr[base]), 32'h01);
    chk("t3_second", 32'(log_addr[base+1]), 32'h02);
    chk("t3_gap", 32'(log_cyc[base+1] - log_cyc[base]), 32'd5);
    chk("t3_i_readdata", i_readdata, init_val(6'h02));
    tick(1);

    // both held for two transactions each: D,I,D,I
    mem_lat = 1; base = log_addr.size();
    d_address = 6'h0A; i_address = 6'h0B; d_read = 1; i_read = 1;
    serve(2, 2, 80, w);
    $display("T4 held order=%h,%h,%h,%h", log_addr[base], log_addr[base+1], log_addr[base+2], log_addr[base+3]);
    chk("t4_g0", 32'(log_addr[base]), 32'h0A);
    chk("t4_g1", 32'(log_addr[base+1]), 32'h0B);
    chk("t4_g2", 32'(log_addr[base+2]), 32'h0A);
    chk("t4_g3", 32'(log_addr[base+3]), 32'h0B);
    tick(1);

    // read and write together: one write, no read
    mem_lat = 2; base = log_addr.size(); rd0 = mem_read_cnt;
    d_address = 6'h10; d_writedata = 32'hCAFEF00D; d_read = 1; d_write = 1;
    serve(1, 0, 40, w);
    $display("T5 rw-both addr=10 mem=%h", mem_arr[16]);
    chk("t5_count", 32'(log_addr.size() - base), 32'd1);
    chk("t5_is_write", 32'(log_wr[base]), 32'd1);
    chk("t5_no_read", 32'(mem_read_cnt - rd0), 32'd0);
    chk("t5_mem", mem_arr[16], 32'hCAFEF00D);
    tick(1);

    // request dropped mid-access still completes
    mem_lat = 4; base = log_addr.size();
    d_address = 6'h07; d_read = 1;
    tick(2);
    d_read = 0;
    tick(10);
    $display("T6 dropped read addr=07 data=%h", d_readdata);
    chk("t6_count", 32'(log_addr.size() - base), 32'd1);
    chk("t6_readdata", d_readdata, 32'h0BADF00D);

    // reset in the middle of an icache access
    mem_lat = 6;
    i_address = 6'h20; i_read = 1;
    tick(3);
    chk("t7_pre_mem_read", 32'(mem_read), 32'd1);
    chk("t7_pre_busy", 32'(mem_busywait), 32'd1);
    chk("t7_pre_i_readdata", i_readdata, init_val(6'h0B));
    reset = 1; i_read = 0;
    tick(1);
    $display("T7 reset mid-access mem_read=%0d i_readdata=%h", mem_read, i_readdata);
    chk("t7_mem_read", 32'(mem_read), 32'd0);
    chk("t7_i_readdata", i_readdata, 32'd0);
    chk("t7_i_busywait", 32'(i_busywait), 32'd0);
    reset = 0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BLK_ADDR_W, default 6, block-address width (8-bit byte address minus 2-bit offset).
REQ-002 SHALL have parameter BLK_DATA_W, default 32, memory block width in bits.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have data-cache ports, all inputs unless noted: d_read 1; d_write 1; d_address BLK_ADDR_W; d_writedata BLK_DATA_W; d_readdata output BLK_DATA_W; d_busywait output 1.
REQ-006 SHALL have instruction-cache ports: i_read input 1; i_address input BLK_ADDR_W; i_readdata output BLK_DATA_W; i_busywait output 1 (read-only requester).
REQ-007 SHALL have memory ports: mem_read output 1; mem_write output 1; mem_address output BLK_ADDR_W; mem_writedata output BLK_DATA_W; mem_readdata input BLK_DATA_W; mem_busywait input 1.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS_D, ACCESS_I.
REQ-009 SHALL define d_req = (d_read|d_write) & ~d_ack and i_req = i_read & ~i_ack, where d_ack/i_ack are registered one-cycle pulses.
REQ-010 In IDLE, on an edge with a single request, SHALL enter the matching ACCESS state and register address, writedata, direction.
REQ-011 On simultaneous d_req and i_req in IDLE, SHALL grant dcache (priority policy changes only per REQ-022).
REQ-012 If d_read and d_write are both high, SHALL perform a write.
REQ-013 During ACCESS_x, SHALL hold mem_read/mem_write, mem_address, mem_writedata constant from registers; both strobes low in IDLE.
REQ-014 Completion SHALL be the first edge in ACCESS_x, excluding the state's entry cycle, with mem_busywait low.
REQ-015 At completion SHALL capture mem_readdata into x_readdata (reads only), pulse x_ack for exactly one cycle, return to IDLE.
REQ-016 x_readdata SHALL hold its value until that requester's next read completion.
REQ-017 d_busywait SHALL equal (d_read|d_write) & ~d_ack and i_busywait SHALL equal i_read & ~i_ack, combinationally.
REQ-018 A requester whose ack is high SHALL be excluded from arbitration in that cycle, so the other pending requester is granted then.
REQ-019 Latency SHALL be 1 cycle grant + memory busy time + 1 cycle ack; no back-to-back access to the same requester without one ack cycle.
REQ-020 Requests dropped mid-access SHALL NOT abort the memory transaction; it completes and the ack is still issued.

Reset
REQ-021 On reset edge: state IDLE, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, d_readdata=0, i_readdata=0, d_ack=0, i_ack=0, last-grant register=I; reset mid-access abandons the transaction with strobes low the next cycle.

Configuration
REQ-022 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests SHALL be granted to the requester not granted most recently (last-grant updated at each grant); when undefined, dcache SHALL always win and the last-grant register SHALL be absent.

Structure
REQ-023 Shared package SHALL hold the FSM state enum, the requester-id type (REQ_D, REQ_I), BLK_ADDR_W/BLK_DATA_W defaults.
REQ-024 Grant selection SHALL be a sub-module arb_pick (inputs d_req, i_req, last_grant; output grant id, valid); FSM and datapath stay in mem_arbiter.

Verification
REQ-025 d_read, d_address=6'h05, memory busy 5 cycles returning 32'hDEADBEEF -> mem_read high with mem_address 05 for the access, d_readdata=DEADBEEF and d_busywait low one cycle after completion.
REQ-026 d_write, d_address=6'h3F, d_writedata=32'h12345678 -> mem_write high, mem_writedata=12345678, mem_read never high, i_busywait unaffected.
REQ-027 d_read and i_read raised same cycle -> dcache served first, icache granted on dcache ack cycle; with ARB_ROUND_ROBIN_EN, second conflict grants icache first.
REQ-028 Both requesters held continuously over 4 transactions with ARB_ROUND_ROBIN_EN -> grants alternate D,I,D,I; without macro -> still alternate via REQ-018 masking, no starvation.
REQ-029 reset asserted during ACCESS_I with mem_busywait high -> next cycle state IDLE, mem_read=0, i_readdata=0, i_ack=0.
REQ-030 d_read and d_write both high, address 6'h10 -> single write transaction, no read issued.
